// File: rtl/alsu_to_seven_segment.sv
// Registered 3-bit ALSU whose 6-bit result is shown on a 4-digit seven-segment display.
// Optional: define ALSU_FULL_ADDER_EN to fold cin into the opcode 010 sum.
module alsu_to_seven_segment #(
   parameter     INPUT_PRIORITY = "A",
   parameter int REFRESH_W      = 16
) (
   input  logic [2:0]  A,
   input  logic [2:0]  B,
   input  logic [2:0]  opcode,
   input  logic        cin,
   input  logic        serial_in,
   input  logic        direction,
   input  logic        red_op_A,
   input  logic        red_op_B,
   input  logic        byPass_A,
   input  logic        byPass_B,
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  anode,
   output logic [6:0]  cathode,
   output logic [15:0] leds
);

   localparam bit PRI_A = (INPUT_PRIORITY == "A");
`ifdef ALSU_FULL_ADDER_EN
   localparam bit FA = 1'b1;
`else
   localparam bit FA = 1'b0;
`endif

   logic [2:0]           a_q, b_q, op_q;
   logic                 cin_q, sin_q, dir_q;
   logic                 ra_q, rb_q, ba_q, bb_q;
   logic [5:0]           out, nxt;
   logic                 err, inv, pick_a, byp_a;
   logic [REFRESH_W-1:0] cnt;
   logic [1:0]           dig;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Reductions only make sense on the two logic opcodes
   always_comb begin
      inv    = (op_q[2] & op_q[1]) |
               ((ra_q | rb_q) & (op_q[2] | op_q[1]));
      pick_a = ra_q & (~rb_q | PRI_A);
      byp_a  = ba_q & (~bb_q | PRI_A);
      nxt    = out;
      if (ba_q | bb_q) begin
         nxt = byp_a ? {3'b000, a_q} : {3'b000, b_q};
      end else if (inv) begin
         nxt = '0;
      end else begin
         case (op_q)
            3'b000: begin
               if (ra_q | rb_q)
                  nxt = {5'b0, pick_a ? &a_q : &b_q};
               else
                  nxt = {3'b000, a_q & b_q};
            end
            3'b001: begin
               if (ra_q | rb_q)
                  nxt = {5'b0, pick_a ? ^a_q : ^b_q};
               else
                  nxt = {3'b000, a_q ^ b_q};
            end
            3'b010: nxt = {3'b000, a_q} + {3'b000, b_q} + {5'b0, cin_q & FA};
            3'b011: nxt = {3'b000, a_q} * {3'b000, b_q};
            3'b100: nxt = dir_q ? {out[4:0], sin_q} : {sin_q, out[5:1]};
            3'b101: nxt = dir_q ? {out[4:0], out[5]} : {out[0], out[5:1]};
            default: nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         cin_q <= 1'b0;
         sin_q <= 1'b0;
         dir_q <= 1'b0;
         ra_q  <= 1'b0;
         rb_q  <= 1'b0;
         ba_q  <= 1'b0;
         bb_q  <= 1'b0;
         out   <= '0;
         err   <= 1'b0;
         leds  <= '0;
         cnt   <= '0;
      end else begin
         a_q   <= A;
         b_q   <= B;
         op_q  <= opcode;
         cin_q <= cin;
         sin_q <= serial_in;
         dir_q <= direction;
         ra_q  <= red_op_A;
         rb_q  <= red_op_B;
         ba_q  <= byPass_A;
         bb_q  <= byPass_B;
         out   <= nxt;
         err   <= inv;
         leds  <= inv ? ~leds : '0;
         cnt   <= cnt + 1'b1;
      end
   end

   assign dig = cnt[REFRESH_W-1 -: 2];

   always_comb begin
      anode      = 4'b1111;
      anode[dig] = 1'b0;
      if (err) begin
         cathode = 7'b0000110;
      end else begin
         case (dig)
            2'd0:    cathode = glyph(out[3:0]);
            2'd1:    cathode = glyph({2'b00, out[5:4]});
            default: cathode = 7'b1111111;
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_to_seven_segment.sv
// Bench for alsu_to_seven_segment: directed vector table, corner sequences,
// and random stimulus against an arithmetic reference model.
module tb_alsu_to_seven_segment;

   typedef struct {
      logic [2:0] a, b, op;
      logic       cin, sin, dir, ra, rb, ba, bb;
   } in_t;

   typedef struct {
      in_t        i;
      logic [5:0] exp;
   } vec_t;

`ifdef ALSU_FULL_ADDER_EN
   localparam bit FA = 1'b1;
`else
   localparam bit FA = 1'b0;
`endif
   localparam bit PRI_A = 1'b1;

   logic [2:0]  A, B, opcode;
   logic        cin, serial_in, direction;
   logic        red_op_A, red_op_B, byPass_A, byPass_B;
   logic        clk, rst;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic [15:0] leds;

   int total = 0;
   int bad   = 0;

   in_t         cur, m_reg;
   int          m_out, m_cnt;
   bit          m_err;
   logic [15:0] m_leds;

   alsu_to_seven_segment #(
      .INPUT_PRIORITY ("A"),
      .REFRESH_W      (4)
   ) dut (
      .A         (A),
      .B         (B),
      .opcode    (opcode),
      .cin       (cin),
      .serial_in (serial_in),
      .direction (direction),
      .red_op_A  (red_op_A),
      .red_op_B  (red_op_B),
      .byPass_A  (byPass_A),
      .byPass_B  (byPass_B),
      .clk       (clk),
      .rst       (rst),
      .anode     (anode),
      .cathode   (cathode),
      .leds      (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   // Glyphs described by which segments light up
   function automatic logic [6:0] seg(input int v);
      string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                         "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                         "cdefg", "adef", "bcdeg", "adefg", "aefg"};
      logic [6:0] g = 7'h7F;
      string s = lit[v];
      for (int k = 0; k < s.len(); k++) g[s[k] - 8'd97] = 1'b0;
      return g;
   endfunction

   function automatic in_t mk(int a, int b, int op, bit c, bit ra,
                              bit rb, bit ba, bit bb);
      in_t r;
      r.a = 3'(a); r.b = 3'(b); r.op = 3'(op); r.cin = c;
      r.sin = 0; r.dir = 0; r.ra = ra; r.rb = rb; r.ba = ba; r.bb = bb;
      return r;
   endfunction

   function automatic bit is_inv(in_t r);
      return (r.op >= 6) || ((r.ra || r.rb) && r.op >= 2);
   endfunction

   function automatic int calc(in_t r, int o);
      int x;
      x = (r.ra && (!r.rb || PRI_A)) ? int'(r.a) : int'(r.b);
      if (r.ba || r.bb) return (r.ba && (!r.bb || PRI_A)) ? int'(r.a) : int'(r.b);
      if (is_inv(r)) return 0;
      case (r.op)
         0: return (r.ra || r.rb) ? ((x == 7) ? 1 : 0) : int'(r.a & r.b);
         1: return (r.ra || r.rb) ? ($countones(x) % 2) : int'(r.a ^ r.b);
         2: return int'(r.a) + int'(r.b) + (FA ? int'(r.cin) : 0);
         3: return int'(r.a) * int'(r.b);
         4: return r.dir ? (o * 2 + int'(r.sin)) % 64 : o / 2 + int'(r.sin) * 32;
         default: return r.dir ? (o * 2) % 64 + o / 32 : o / 2 + (o % 2) * 32;
      endcase
   endfunction

   task automatic drive(in_t r);
      cur = r;
      A = r.a; B = r.b; opcode = r.op; cin = r.cin;
      serial_in = r.sin; direction = r.dir;
      red_op_A = r.ra; red_op_B = r.rb; byPass_A = r.ba; byPass_B = r.bb;
   endtask

   task automatic model_reset();
      m_reg = mk(0, 0, 0, 0, 0, 0, 0, 0);
      m_out = 0; m_err = 0; m_leds = '0; m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      int k;
      logic [6:0] ec;
      k = (m_cnt / 4) % 4;
      if (m_err) ec = seg(14);
      else if (k == 0) ec = seg(m_out % 16);
      else if (k == 1) ec = seg(m_out / 16);
      else ec = 7'h7F;
      chk({tag, ".out"}, 32'(dut.out), 32'(m_out));
      chk({tag, ".leds"}, 32'(leds), 32'(m_leds));
      chk({tag, ".anode"}, 32'(anode), 32'(15 - (1 << k)));
      chk({tag, ".cathode"}, 32'(cathode), 32'(ec));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      m_out  = calc(m_reg, m_out);
      m_leds = is_inv(m_reg) ? ~m_leds : 16'h0000;
      m_err  = is_inv(m_reg);
      m_reg  = cur;
      m_cnt  = (m_cnt + 1) % 16;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #2;
      model_reset();
      chk({tag, ".rst_out"}, 32'(dut.out), 0);
      chk({tag, ".rst_leds"}, 32'(leds), 0);
      chk({tag, ".rst_anode"}, 32'(anode), 32'b1110);
      chk({tag, ".rst_cathode"}, 32'(cathode), 32'b1000000);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      vec_t        vt[$];
      in_t         r;
      logic [15:0] l1, l2;

      rst = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      @(negedge clk);
      do_reset("init");

      vt.push_back('{mk(1, 2, 0, 0, 0, 0, 1, 0), 6'd1});
      vt.push_back('{mk(1, 2, 0, 0, 0, 0, 0, 1), 6'd2});
      vt.push_back('{mk(7, 4, 0, 0, 0, 0, 1, 1), 6'd7});
      vt.push_back('{mk(2, 3, 2, 0, 0, 0, 0, 0), 6'd5});
      vt.push_back('{mk(2, 3, 3, 0, 0, 0, 0, 0), 6'd6});
      vt.push_back('{mk(2, 3, 2, 1, 0, 0, 0, 0), FA ? 6'd6 : 6'd5});
      vt.push_back('{mk(7, 4, 0, 0, 1, 0, 0, 0), 6'd1});
      vt.push_back('{mk(7, 4, 0, 0, 0, 1, 0, 0), 6'd0});
      vt.push_back('{mk(7, 4, 1, 0, 0, 0, 0, 0), 6'd3});
      vt.push_back('{mk(7, 4, 0, 0, 1, 1, 0, 0), 6'd1});
      vt.push_back('{mk(5, 5, 1, 0, 0, 0, 0, 0), 6'd0});
      vt.push_back('{mk(7, 7, 3, 0, 0, 0, 0, 0), 6'd49});
      vt.push_back('{mk(6, 3, 1, 0, 0, 1, 0, 0), 6'd0});
      vt.push_back('{mk(7, 7, 2, 1, 0, 0, 0, 0), FA ? 6'd15 : 6'd14});
      vt.push_back('{mk(2, 3, 3, 0, 1, 0, 0, 0), 6'd0});

      foreach (vt[k]) begin
         drive(vt[k].i);
         step($sformatf("v%0d", k));
         step($sformatf("v%0d", k));
         chk($sformatf("vec%0d", k), 32'(dut.out), 32'(vt[k].exp));
      end

      // Invalid op held: leds blink, all digits read E, reset clears mid-blink
      for (int k = 0; k < 5; k++) step("blink");
      l1 = leds;
      chk("blink_E", 32'(cathode), 32'b0000110);
      step("blink");
      l2 = leds;
      chk("blink_toggle", 32'(l1 ^ l2), 32'hFFFF);
      chk("blink_level", 32'(l1 == 16'hFFFF || l1 == 16'h0000), 1);
      do_reset("blink");

      // Shift left three times, then rotate right once
      r = mk(0, 0, 4, 0, 0, 0, 0, 0);
      r.dir = 1; r.sin = 1;
      drive(r);
      for (int k = 0; k < 3; k++) step("shl");
      r = mk(0, 0, 5, 0, 0, 0, 0, 0);
      drive(r);
      step("shl");
      chk("shift3", 32'(dut.out), 32'b000111);
      step("ror");
      chk("rotate", 32'(dut.out), 32'b100011);
      r = mk(0, 0, 4, 0, 0, 0, 0, 0);
      r.dir = 1; r.sin = 1;
      drive(r);
      step("shl2");
      step("shl2");
      do_reset("midshift");

      for (int n = 0; n < 400; n++) begin
         r.a   = 3'($urandom_range(7, 0));
         r.b   = 3'($urandom_range(7, 0));
         r.op  = 3'($urandom_range(7, 0));
         r.cin = 1'($urandom_range(1, 0));
         r.sin = 1'($urandom_range(1, 0));
         r.dir = 1'($urandom_range(1, 0));
         r.ra  = ($urandom_range(3, 0) == 0);
         r.rb  = ($urandom_range(3, 0) == 0);
         r.ba  = ($urandom_range(7, 0) == 0);
         r.bb  = ($urandom_range(7, 0) == 0);
         drive(r);
         step("rnd");
         if (n == 200) do_reset("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
